// File: rtl/pattern_checker.sv
// Receive-side checker for the fixed alternating-bit pattern: hunts for alignment, locks, and counts errors.
// Optional sticky per-lane error mask output is enabled by defining PATTERN_CHECKER_ERRMASK_EN.
module pattern_checker #(
  parameter int           W      = 32,
  parameter logic [W-1:0] EXP    = W'({32{2'b10}}),
  parameter bit           TOGGLE = 1'b0,
  parameter int           LOCK_N = 4,
  parameter int           LOSS_N = 4,
  parameter int           CW     = 16
) (
  input  logic          c,
  input  logic          rn,
  input  logic          en,
  input  logic          clr,
  input  logic          vld,
  input  logic [W-1:0]  d,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] word_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] bit_err_cnt,
  output logic [3:0]    loss_cnt
`ifdef PATTERN_CHECKER_ERRMASK_EN
  ,
  output logic [W-1:0]  err_mask
`endif
);

  localparam int PW = $clog2(W + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          phase, phase_nx;
  logic [3:0]    run, run_nx;
  logic [3:0]    miss, miss_nx;
  logic          hit, bad, lose;

  logic [W-1:0]  exp_w;
  logic [W-1:0]  diff;
  logic          match, inverse;
  logic [PW-1:0] pc;
  logic [SW-1:0] bit_sum;

  assign exp_w   = EXP ^ {W{1'(TOGGLE) & phase}};
  assign diff    = d ^ exp_w;
  assign match   = (diff == '0);
  // An exactly inverted word means the stream is one word out of phase.
  assign inverse = TOGGLE && (diff == '1);

  always_comb begin
    pc = '0;
    for (int j = 0; j < W; j++) pc = pc + PW'(diff[j]);
  end

  assign bit_sum = SW'(bit_err_cnt) + SW'(pc);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    run_nx   = run;
    miss_nx  = miss;
    hit      = 1'b0;
    bad      = 1'b0;
    lose     = 1'b0;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx = HUNT;
          phase_nx = 1'b0;
          run_nx   = '0;
          miss_nx  = '0;
        end
        HUNT: begin
          if (vld) begin
            if (match) begin
              run_nx   = run + 4'd1;
              phase_nx = phase ^ 1'(TOGGLE);
            end else if (inverse) begin
              run_nx   = 4'd1;
            end else begin
              run_nx   = '0;
              phase_nx = phase ^ 1'(TOGGLE);
            end
            if (run_nx == 4'(LOCK_N)) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end
        end
        LOCKED: begin
          if (vld) begin
            hit      = 1'b1;
            phase_nx = phase ^ 1'(TOGGLE);
            if (match) begin
              miss_nx = '0;
            end else begin
              bad     = 1'b1;
              miss_nx = miss + 4'd1;
              if (miss_nx == 4'(LOSS_N)) begin
                state_nx = HUNT;
                run_nx   = '0;
                miss_nx  = '0;
                lose     = 1'b1;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
      phase <= 1'b0;
      run   <= '0;
      miss  <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      run   <= run_nx;
      miss  <= miss_nx;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      locked   <= 1'b0;
      err      <= 1'b0;
      loss_cnt <= '0;
    end else begin
      locked <= (state_nx == LOCKED);
      err    <= bad;
      if (lose && (loss_cnt != '1)) loss_cnt <= loss_cnt + 4'd1;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      word_cnt    <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
    end else if (clr) begin
      word_cnt    <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
    end else begin
      if (hit && (word_cnt != '1)) word_cnt <= word_cnt + CW'(1);
      if (bad) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
        // Clamp on the widened sum so a large popcount can never wrap past all-ones.
        if (bit_sum > SW'({CW{1'b1}})) bit_err_cnt <= '1;
        else                           bit_err_cnt <= bit_sum[CW-1:0];
      end
    end
  end

`ifdef PATTERN_CHECKER_ERRMASK_EN
  always_ff @(posedge c or negedge rn) begin
    if (!rn)      err_mask <= '0;
    else if (clr) err_mask <= '0;
    else if (hit) err_mask <= err_mask | diff;
  end
`endif

endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Receive-side checker for the fixed-bit-pattern register bank driven by the per-bit generate-loop pattern source.
- Samples the parallel word on each valid strobe and compares it against the expected pattern. Bit j of the expected word is j%2, optionally inverted on alternate words.
- Hunts for alignment, declares lock, then counts word and bit errors. Intended for link/bring-up self-test, readable by slow control.

Parameters:
- W, 32, data word width (1..64)
- EXP, 32'hAAAA_AAAA, base expected word (bit j = j%2), width W
- TOGGLE, 0, 1 = expected word alternates EXP / ~EXP on successive valid words
- LOCK_N, 4, consecutive matching words required to enter LOCKED (1..15)
- LOSS_N, 4, consecutive mismatching words in LOCKED that force return to HUNT (1..15)
- CW, 16, width of error and word counters

Ports:
- c, input, 1, clock, all logic on rising edge
- rn, input, 1, reset, asynchronous, active-low
- en, input, 1, checker enable; 0 forces IDLE
- clr, input, 1, synchronous clear of all counters (state unaffected)
- vld, input, 1, d is valid this cycle
- d, input, W, received pattern word
- locked, output, 1, FSM in LOCKED
- err, output, 1, one-cycle pulse: mismatching word seen while LOCKED
- word_cnt, output, CW, valid words checked while LOCKED
- err_cnt, output, CW, mismatching words while LOCKED
- bit_err_cnt, output, CW, total mismatching bits while LOCKED
- loss_cnt, output, 4, number of LOCKED->HUNT transitions

Behaviour:
- Reset (rn=0, async): state IDLE, phase=0, run counter=0. All outputs 0.
- Expected word exp = EXP ^ ({W{TOGGLE & phase}}). phase flips on every vld while in HUNT or LOCKED. phase is frozen when TOGGLE=0.
- A word matches when d == exp. Bit errors = popcount(d ^ exp), 0..W.
- FSM:
  - IDLE: en=1 -> HUNT (phase=0, run=0).
  - HUNT: on vld, match -> run+1; mismatch -> run=0.
  - HUNT, TOGGLE=1: a mismatch whose d == ~exp re-aligns phase (phase not flipped this word) and sets run=1.
  - HUNT: run reaches LOCK_N -> LOCKED, next cycle. Counters untouched.
  - LOCKED: every vld increments word_cnt. Mismatch increments err_cnt, adds bit errors to bit_err_cnt, pulses err one cycle after the vld, and increments the miss run. Match clears the miss run.
  - LOCKED: miss run reaches LOSS_N -> HUNT, run=0, loss_cnt+1.
  - Any state: en=0 -> IDLE next cycle. Counters hold their value.
- Latency: locked and err register one cycle after the deciding vld. Counters update in the same cycle as err.
- Saturation: all counters saturate at all-ones and never wrap. bit_err_cnt saturates on the add; it does not wrap and then clamp.
- clr and an update in the same cycle: clr wins, counter = 0. clr does not touch locked, loss_cnt, or the runs.
- vld=0: no state or counter change. d is ignored.
- rn asserted mid-operation: immediate return to reset values. Nothing is retained.

Optional Feature:
- Macro: PATTERN_CHECKER_ERRMASK_EN.
- Defined: adds output err_mask [W-1:0], a sticky OR of (d ^ exp) over all LOCKED vld words. Cleared by reset and clr. Identifies stuck or crossed bit lanes.
- Undefined: port and logic absent. All other behaviour identical.

Test Plan:
- Lock, TOGGLE=0: en=1, 4 vld words of 0xAAAAAAAA -> locked=1 one cycle after the 4th word; then 10 good words -> word_cnt=10, err_cnt=0.
- Single-bit error: locked, inject 0xAAAAAAAB -> err pulse for 1 cycle, err_cnt=1, bit_err_cnt=1. With ERRMASK_EN: err_mask=0x00000001.
- Loss of lock: locked, 4 consecutive words 0x55555555 -> err_cnt=4, bit_err_cnt=128, locked=0, loss_cnt=1. Then 4 good words -> locked=1 again.
- TOGGLE=1 phase alignment: stream starts with 0x55555555, 0xAAAAAAAA, ... -> realigned, locked after LOCK_N words, err_cnt=0.
- Saturation and clr: CW=4, 20 bad words while LOCKED with LOSS_N=15 -> err_cnt=15 (not wrapped). clr together with a bad word -> err_cnt=0.
- Async reset mid-lock: rn pulsed low between clock edges -> locked=0 and all counters 0 immediately. Gaps of vld=0 between words do not break lock or change counters.
